// File: rtl/dual_port_sync_ram_if.sv
// Bus bundle for dual_port_sync_ram: write port A and read port B.
// The master drives the requests and the slave (the RAM) returns the read results.
interface dual_port_sync_ram_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_WIDTH = 8
);
  logic                             a_cs;
  logic                             a_we;
  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_be;
  logic [ADDR_WIDTH-1:0]            a_addr;
  logic [DATA_WIDTH-1:0]            a_wdata;
  logic                             b_cs;
  logic [ADDR_WIDTH-1:0]            b_addr;
  logic [DATA_WIDTH-1:0]            b_rdata;
  logic                             b_valid;
  logic                             b_oor;

  modport master (
    output a_cs, a_we, a_be, a_addr, a_wdata, b_cs, b_addr,
    input  b_rdata, b_valid, b_oor
  );

  modport slave (
    input  a_cs, a_we, a_be, a_addr, a_wdata, b_cs, b_addr,
    output b_rdata, b_valid, b_oor
  );
endinterface

// File: rtl/dual_port_sync_ram.sv
// Simple dual-port synchronous RAM with byte-enabled writes and a selectable read-during-write policy.
// It has an optional second output register and a read-valid pulse that flags out-of-range reads.
module dual_port_sync_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input  logic               clk,
  input  logic               rst,
  dual_port_sync_ram_if.slave bus
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_wrInRange;
  logic                  w_rdInRange;
  logic                  w_wrEn;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_byteMask;
  logic [DATA_WIDTH-1:0] w_oldWord;
  logic [DATA_WIDTH-1:0] w_readWord;

  logic                  r_s1Valid;
  logic [DATA_WIDTH-1:0] r_s1Data;
  logic                  r_s1Oor;

  assign w_wrInRange = {1'b0, bus.a_addr} < DEPTH_LIMIT;
  assign w_rdInRange = {1'b0, bus.b_addr} < DEPTH_LIMIT;
  assign w_wrEn      = bus.a_cs & bus.a_we & w_wrInRange;
  assign w_collide   = w_wrEn & w_rdInRange & (bus.a_addr == bus.b_addr);

  always_comb begin
    w_byteMask = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      w_byteMask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{bus.a_be[i]}};
    end
  end

  // The memory array is deliberately left out of reset so that it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (bus.a_be[i]) begin
          r_mem[bus.a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign w_oldWord  = w_rdInRange ? r_mem[bus.b_addr] : '0;
  assign w_readWord = (RDW_MODE != 0 && w_collide)
                    ? ((w_oldWord & ~w_byteMask) | (bus.a_wdata & w_byteMask))
                    : w_oldWord;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
      r_s1Oor   <= 1'b0;
    end else begin
      r_s1Valid <= bus.b_cs;
      if (bus.b_cs) begin
        r_s1Data <= w_readWord;
        r_s1Oor  <= ~w_rdInRange;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_outReg
      logic                  r_s2Valid;
      logic [DATA_WIDTH-1:0] r_s2Data;
      logic                  r_s2Oor;

      // Data and the out-of-range flag hold between reads, so only the valid bit pulses.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s2Valid <= 1'b0;
          r_s2Data  <= '0;
          r_s2Oor   <= 1'b0;
        end else begin
          r_s2Valid <= r_s1Valid;
          if (r_s1Valid) begin
            r_s2Data <= r_s1Data;
            r_s2Oor  <= r_s1Oor;
          end
        end
      end

      assign bus.b_valid = r_s2Valid;
      assign bus.b_rdata = r_s2Data;
      assign bus.b_oor   = r_s2Oor;
    end else begin : g_noOutReg
      assign bus.b_valid = r_s1Valid;
      assign bus.b_rdata = r_s1Data;
      assign bus.b_oor   = r_s1Oor;
    end
  endgenerate
endmodule
